uart_rx_frame_counter: RTL and testbench
========================================

Name: uart_rx_frame_counter

Overview:
Parametrised edge/bit timing engine for the UART receiver. It counts oversampling edges within each bit and bits within each frame. Data width, parity and stop-bit count are run-time configurable. It produces mid-bit sample strobes, a frame field code and frame-completion pulses, and supports back-to-back frames. It sits between the RX FSM (which drives enable) and the data sampler / deserializer / checkers.

Parameters:
MAX_PRESCALE, 32, largest legal oversampling ratio.
MAX_DATA_WIDTH, 9, largest data field in bits.
PRSC_WIDTH, $clog2(MAX_PRESCALE)+1, width of prescale input.
BIT_WIDTH, $clog2(MAX_DATA_WIDTH+4)+1, width of bit_cnt (holds frame length).
DW_WIDTH, $clog2(MAX_DATA_WIDTH)+1, width of data_width input.

Ports:
clk  in  1  system clock; all logic on posedge.
rst  in  1  asynchronous, active-low reset.
enable  in  1  run request from RX FSM; low clears counters.
prescale  in  PRSC_WIDTH  oversampling ratio; legal range 4..MAX_PRESCALE.
data_width  in  DW_WIDTH  data bits per frame; legal range 5..MAX_DATA_WIDTH.
parity_en  in  1  frame includes a parity bit.
stop2  in  1  0: one stop bit, 1: two stop bits.
edge_cnt  out  PRSC_WIDTH-1  edge index within the current bit.
bit_cnt  out  BIT_WIDTH  bit index within the frame; 0 is the start bit.
edge_max  out  1  comb; edge_cnt == prescale_q-1.
sample_stb  out  1  comb; high on the three mid-bit edges.
field  out  2  comb; 00 start, 01 data, 10 parity, 11 stop.
frame_done  out  1  registered; one-cycle pulse after the last edge of the last stop bit.
cfg_err  out  1  registered; latched configuration is illegal.

Behaviour:
- Reset: edge_cnt=0, bit_cnt=0, frame_done=0, cfg_err=0, state IDLE, latched config = prescale 4, data_width 8, no parity, one stop bit.
- States: IDLE and RUN.
  - IDLE -> RUN on the cycle enable is sampled high. In that same cycle, latch prescale_q, dw_q, par_q, stop2_q. Counters stay 0 that cycle.
  - RUN -> IDLE on the cycle enable is sampled low. Counters clear to 0 on that edge. frame_done is not asserted. Abort mid-frame is legal.
- Frame length: FL = 1 + dw_q + par_q + 1 + stop2_q (range 7..MAX_DATA_WIDTH+4).
- RUN counting:
  - edge_cnt increments each cycle and wraps to 0 when edge_max is high.
  - bit_cnt increments when edge_max is high.
  - On edge_max with bit_cnt==FL-1: bit_cnt wraps to 0 and frame_done pulses on the next cycle.
- Back-to-back frames: if enable is still high at the wrap, RUN continues with no gap cycle. Config is re-latched on the wrap edge, so the new config takes effect from the next start bit. Inputs are ignored mid-frame.
- sample_stb: mid = prescale_q>>1. sample_stb is high when RUN and edge_cnt is mid-1, mid or mid+1.
  - prescale_q=8: edges 3,4,5.
  - prescale_q=5: edges 1,2,3.
- field decode:
  - bit_cnt 0 -> start.
  - 1..dw_q -> data.
  - dw_q+1 -> parity when par_q, otherwise stop.
  - All higher indices -> stop.
- Illegal config: prescale_q <4 or >MAX_PRESCALE, or dw_q outside 5..MAX_DATA_WIDTH.
  - cfg_err=1 from the cycle after latch.
  - Counters held at 0, sample_stb and frame_done held 0.
  - cfg_err clears only on the next latch of a legal config, via IDLE.
- Arithmetic: all compares are unsigned and zero-extended to the wider operand. No combinational path from inputs to outputs except through the latched config (edge_max, sample_stb and field depend on registers only).
- Simultaneous events: enable low on the final edge_max of a frame -> abort wins; counters clear and no frame_done.

Optional Feature:
FRAME_CNT_EN
- Defined: adds output frame_cnt [15:0]. Reset 0; increments on each frame_done; saturates at 16'hFFFF. Not cleared by enable.
- Undefined: port and logic absent; all other behaviour unchanged.

Test Plan:
- Reset mid-RUN at edge_cnt=5, bit_cnt=3 -> all outputs 0 asynchronously; after release, state IDLE.
- prescale=8, data_width=8, parity_en=0, stop2=0, enable held 1 -> FL=10; frame_done after 80 RUN cycles; sample_stb on edges 3,4,5 of every bit; field = 00, 01×8, 11.
- prescale=16, data_width=7, parity_en=1, stop2=1 -> FL=11; field=10 at bit_cnt 8; frame_done after 176 cycles; second frame begins the next cycle with edge_cnt=0, bit_cnt=0.
- Change data_width from 8 to 5 mid-frame -> current frame ends at FL=10; next frame FL=7.
- Drop enable at bit_cnt=9, edge_cnt=7 (prescale=8) -> counters 0 next cycle, no frame_done; re-enable -> fresh frame.
- prescale=3 or data_width=10 -> cfg_err=1, counters 0, no strobes; deassert enable and restart with prescale=8 -> cfg_err clears. With FRAME_CNT_EN, 3 frames -> frame_cnt=3.

Source files
------------

// File: rtl/uart_rx_frame_counter_if.sv
// Interface between the RX FSM / sampler side and the UART RX edge/bit timing engine.
// Optional frame_cnt signal is present only when FRAME_CNT_EN is defined.
interface uart_rx_frame_counter_if #(
    parameter int MAX_PRESCALE   = 32,
    parameter int MAX_DATA_WIDTH = 9,
    parameter int PRSC_WIDTH     = $clog2(MAX_PRESCALE) + 1,
    parameter int BIT_WIDTH      = $clog2(MAX_DATA_WIDTH + 4) + 1,
    parameter int DW_WIDTH       = $clog2(MAX_DATA_WIDTH) + 1
);
    logic                  i_enable;
    logic [PRSC_WIDTH-1:0] i_prescale;
    logic [DW_WIDTH-1:0]   i_data_width;
    logic                  i_parity_en;
    logic                  i_stop2;

    logic [PRSC_WIDTH-2:0] o_edge_cnt;
    logic [BIT_WIDTH-1:0]  o_bit_cnt;
    logic                  o_edge_max;
    logic                  o_sample_stb;
    logic [1:0]            o_field;
    logic                  o_frame_done;
    logic                  o_cfg_err;
`ifdef FRAME_CNT_EN
    logic [15:0]           o_frame_cnt;

    modport master (
        output i_enable, i_prescale, i_data_width, i_parity_en, i_stop2,
        input  o_edge_cnt, o_bit_cnt, o_edge_max, o_sample_stb, o_field,
               o_frame_done, o_cfg_err, o_frame_cnt
    );

    modport slave (
        input  i_enable, i_prescale, i_data_width, i_parity_en, i_stop2,
        output o_edge_cnt, o_bit_cnt, o_edge_max, o_sample_stb, o_field,
               o_frame_done, o_cfg_err, o_frame_cnt
    );
`else
    modport master (
        output i_enable, i_prescale, i_data_width, i_parity_en, i_stop2,
        input  o_edge_cnt, o_bit_cnt, o_edge_max, o_sample_stb, o_field,
               o_frame_done, o_cfg_err
    );

    modport slave (
        input  i_enable, i_prescale, i_data_width, i_parity_en, i_stop2,
        output o_edge_cnt, o_bit_cnt, o_edge_max, o_sample_stb, o_field,
               o_frame_done, o_cfg_err
    );
`endif
endinterface

// File: rtl/uart_rx_frame_counter.sv
// UART RX edge/bit timing engine: counts oversampling edges per bit and bits per frame.
// Define FRAME_CNT_EN to add a saturating 16-bit completed-frame counter.
module uart_rx_frame_counter #(
    parameter int MAX_PRESCALE   = 32,
    parameter int MAX_DATA_WIDTH = 9,
    parameter int PRSC_WIDTH     = $clog2(MAX_PRESCALE) + 1,
    parameter int BIT_WIDTH      = $clog2(MAX_DATA_WIDTH + 4) + 1,
    parameter int DW_WIDTH       = $clog2(MAX_DATA_WIDTH) + 1
) (
    input logic                    i_clk,
    input logic                    i_rst,
    uart_rx_frame_counter_if.slave bus
);
    localparam int CW = ((BIT_WIDTH > DW_WIDTH) ? BIT_WIDTH : DW_WIDTH) + 1;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    typedef struct packed {
        logic [PRSC_WIDTH-1:0] prescale;
        logic [DW_WIDTH-1:0]   dw;
        logic                  par;
        logic                  stop2;
    } cfg_t;

    localparam cfg_t L_CFG_RST = '{prescale: PRSC_WIDTH'(4), dw: DW_WIDTH'(8),
                                   par: 1'b0, stop2: 1'b0};
    localparam logic [PRSC_WIDTH:0] L_ONE_X = (PRSC_WIDTH+1)'(1);

    state_t                r_state;
    cfg_t                  r_cfg;
    logic [PRSC_WIDTH-2:0] r_edge_cnt;
    logic [BIT_WIDTH-1:0]  r_bit_cnt;
    logic                  r_frame_done;
    logic                  r_cfg_err;

    cfg_t                  w_cfg_in;
    logic                  w_in_illegal;
    logic                  w_active;
    logic [PRSC_WIDTH-1:0] w_prsc_m1;
    logic                  w_edge_max;
    logic [CW-1:0]         w_bit_x;
    logic [CW-1:0]         w_dw_x;
    logic [CW-1:0]         w_last_idx;
    logic                  w_last_bit;
    logic [PRSC_WIDTH:0]   w_edge_x;
    logic [PRSC_WIDTH:0]   w_mid;
    logic                  w_sample_stb;
    logic [1:0]            w_field;

    assign w_cfg_in = '{prescale: bus.i_prescale, dw: bus.i_data_width,
                        par: bus.i_parity_en, stop2: bus.i_stop2};

    // Legality is judged on the value being latched so cfg_err appears the cycle after latch.
    assign w_in_illegal = (bus.i_prescale   < PRSC_WIDTH'(4))
                       || (bus.i_prescale   > PRSC_WIDTH'(MAX_PRESCALE))
                       || (bus.i_data_width < DW_WIDTH'(5))
                       || (bus.i_data_width > DW_WIDTH'(MAX_DATA_WIDTH));

    assign w_active   = (r_state == ST_RUN) && !r_cfg_err;
    assign w_prsc_m1  = r_cfg.prescale - PRSC_WIDTH'(1);
    assign w_edge_max = w_active && ({1'b0, r_edge_cnt} == w_prsc_m1);

    assign w_bit_x    = CW'(r_bit_cnt);
    assign w_dw_x     = CW'(r_cfg.dw);
    assign w_last_idx = w_dw_x + CW'(r_cfg.par) + CW'(r_cfg.stop2) + CW'(1);
    assign w_last_bit = (w_bit_x == w_last_idx);

    assign w_edge_x     = (PRSC_WIDTH+1)'(r_edge_cnt);
    assign w_mid        = {1'b0, r_cfg.prescale >> 1};
    assign w_sample_stb = w_active && ((w_edge_x + L_ONE_X == w_mid)
                                    || (w_edge_x == w_mid)
                                    || (w_edge_x == w_mid + L_ONE_X));

    always_comb begin
        w_field = 2'b11;
        if (r_bit_cnt == '0)
            w_field = 2'b00;
        else if (w_bit_x <= w_dw_x)
            w_field = 2'b01;
        else if ((w_bit_x == w_dw_x + CW'(1)) && r_cfg.par)
            w_field = 2'b10;
    end

`ifdef FRAME_CNT_EN
    logic [15:0] r_frame_cnt;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would let later statements see updated state.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= ST_IDLE;
            r_cfg        <= L_CFG_RST;
            r_edge_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_frame_done <= 1'b0;
            r_cfg_err    <= 1'b0;
`ifdef FRAME_CNT_EN
            r_frame_cnt  <= '0;
`endif
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.i_enable) begin
                        r_state   <= ST_RUN;
                        r_cfg     <= w_cfg_in;
                        r_cfg_err <= w_in_illegal;
                    end
                end
                ST_RUN: begin
                    if (!bus.i_enable) begin
                        r_state    <= ST_IDLE;
                        r_edge_cnt <= '0;
                        r_bit_cnt  <= '0;
                    end else if (w_edge_max) begin
                        r_edge_cnt <= '0;
                        if (w_last_bit) begin
                            // Back-to-back frame: new config applies from the next start bit.
                            r_bit_cnt    <= '0;
                            r_frame_done <= 1'b1;
                            r_cfg        <= w_cfg_in;
                            r_cfg_err    <= w_in_illegal;
`ifdef FRAME_CNT_EN
                            if (r_frame_cnt != 16'hFFFF)
                                r_frame_cnt <= r_frame_cnt + 16'd1;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_WIDTH'(1);
                        end
                    end else if (!r_cfg_err) begin
                        r_edge_cnt <= r_edge_cnt + (PRSC_WIDTH-1)'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_edge_cnt   = r_edge_cnt;
    assign bus.o_bit_cnt    = r_bit_cnt;
    assign bus.o_edge_max   = w_edge_max;
    assign bus.o_sample_stb = w_sample_stb;
    assign bus.o_field      = w_field;
    assign bus.o_frame_done = r_frame_done;
    assign bus.o_cfg_err    = r_cfg_err;
`ifdef FRAME_CNT_EN
    assign bus.o_frame_cnt  = r_frame_cnt;
`endif

endmodule

// File: tb/tb_uart_rx_frame_counter.sv
// Directed self-checking bench for uart_rx_frame_counter (default parameters).
// Expected values are computed from frame geometry: edge = c % prescale, bit = c / prescale.
module tb_uart_rx_frame_counter;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   n_frames;

    uart_rx_frame_counter_if bus ();

    uart_rx_frame_counter dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {edge_cnt, bit_cnt, sample_stb, field, edge_max, frame_done, cfg_err}
    function automatic logic [15:0] obs();
        return {bus.o_edge_cnt, bus.o_bit_cnt, bus.o_sample_stb, bus.o_field,
                bus.o_edge_max, bus.o_frame_done, bus.o_cfg_err};
    endfunction

    function automatic logic [15:0] pack(input int e, input int b, input bit stb,
                                         input int f, input bit em, input bit fd,
                                         input bit err);
        return {5'(e), 5'(b), stb, 2'(f), em, fd, err};
    endfunction

    task automatic set_cfg(input int prsc, input int dw, input bit par, input bit st2);
        bus.i_prescale   = 6'(prsc);
        bus.i_data_width = 5'(dw);
        bus.i_parity_en  = par;
        bus.i_stop2      = st2;
    endtask

    // Starts at cycle 0 of a frame (edge 0, bit 0); ends at cycle 0 of the following one.
    task automatic run_frame(input int prsc, input int dw, input bit par, input bit st2,
                             input bit done0);
        int fl;
        int mid;
        fl  = 2 + dw + int'(par) + int'(st2);
        mid = prsc / 2;
        for (int c = 0; c < fl * prsc; c++) begin
            int e;
            int b;
            int f;
            bit stb;
            e   = c % prsc;
            b   = c / prsc;
            stb = (e >= mid - 1) && (e <= mid + 1);
            if (b == 0)                  f = 0;
            else if (b <= dw)            f = 1;
            else if (b == dw + 1 && par) f = 2;
            else                         f = 3;
            check($sformatf("frame p%0d d%0d c%0d", prsc, dw, c), obs(),
                  pack(e, b, stb, f, e == prsc - 1, (c == 0) ? done0 : 1'b0, 1'b0));
            tick();
        end
        n_frames++;
        check($sformatf("frame_done p%0d d%0d", prsc, dw), obs(),
              pack(0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        n_frames = 0;
        rst = 1'b0;
        bus.i_enable = 1'b0;
        set_cfg(8, 8, 1'b0, 1'b0);
        tick();
        tick();
        check("reset_state", obs(), 16'h0000);

        // Async reset mid-RUN at edge 5, bit 3.
        rst = 1'b1;
        bus.i_enable = 1'b1;
        tick();
        repeat (29) tick();
        check("pre_reset_pos", {bus.o_edge_cnt, bus.o_bit_cnt}, {5'd5, 5'd3});
        rst = 1'b0;
        #2;
        check("async_reset", obs(), 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        tick();  // IDLE -> RUN latch; counters remain 0

        // FL=10 frame, then data_width change mid-frame is ignored until the wrap.
        run_frame(8, 8, 1'b0, 1'b0, 1'b0);
        set_cfg(8, 5, 1'b0, 1'b0);
        run_frame(8, 8, 1'b0, 1'b0, 1'b1);
        set_cfg(16, 7, 1'b1, 1'b1);
        run_frame(8, 5, 1'b0, 1'b0, 1'b1);
        set_cfg(8, 8, 1'b0, 1'b0);
        run_frame(16, 7, 1'b1, 1'b1, 1'b1);

        // Abort on the final edge of the frame: no frame_done.
        repeat (79) tick();
        check("abort_pos", {bus.o_edge_cnt, bus.o_bit_cnt, bus.o_edge_max},
              {5'd7, 5'd9, 1'b1});
        bus.i_enable = 1'b0;
        tick();
        check("abort_clear", obs(), 16'h0000);
        tick();
        check("abort_no_done", obs(), 16'h0000);
        bus.i_enable = 1'b1;
        tick();
        run_frame(8, 8, 1'b0, 1'b0, 1'b0);

        // Illegal prescale.
        bus.i_enable = 1'b0;
        set_cfg(3, 8, 1'b0, 1'b0);
        tick();
        bus.i_enable = 1'b1;
        tick();
        check("cfg_err_prsc", obs(), 16'h0001);
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("cfg_err_hold %0d", i), obs(), 16'h0001);
        end
        bus.i_enable = 1'b0;
        tick();
        check("cfg_err_idle", obs(), 16'h0001);
        set_cfg(8, 8, 1'b0, 1'b0);
        bus.i_enable = 1'b1;
        tick();
        check("cfg_err_clear", obs(), 16'h0000);
        run_frame(8, 8, 1'b0, 1'b0, 1'b0);

        // Illegal data_width, then the largest legal one.
        bus.i_enable = 1'b0;
        set_cfg(8, 10, 1'b0, 1'b0);
        tick();
        bus.i_enable = 1'b1;
        tick();
        check("cfg_err_dw", obs(), 16'h0001);
        repeat (10) tick();
        check("cfg_err_dw_hold", obs(), 16'h0001);
        bus.i_enable = 1'b0;
        tick();
        set_cfg(8, 9, 1'b0, 1'b0);
        bus.i_enable = 1'b1;
        tick();
        check("cfg_dw9_ok", obs(), 16'h0000);
        set_cfg(5, 6, 1'b0, 1'b1);
        run_frame(8, 9, 1'b0, 1'b0, 1'b0);
        set_cfg(4, 5, 1'b1, 1'b0);
        run_frame(5, 6, 1'b0, 1'b1, 1'b1);
        run_frame(4, 5, 1'b1, 1'b0, 1'b1);

        bus.i_enable = 1'b0;
        tick();
        check("final_idle", obs(), 16'h0000);
`ifdef FRAME_CNT_EN
        check("frame_cnt", 32'(bus.o_frame_cnt), 32'(n_frames));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
